// File: rtl/tone_synth_pkg.sv
// Shared types and widths for the tone synthesizer.
package tone_synth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        SUSTAIN,
        RELEASE
    } env_state_t;

    localparam int PHASE_W  = 24;
    localparam int FREQ_W   = 10;
    localparam int SAMPLE_W = 16;

    localparam logic [8:0] DEFAULT_INC_SCALE = 9'd350;

endpackage

// File: rtl/tone_envelope.sv
// Attack/sustain/release envelope generator, advanced once per sample tick.
// The amp output is the amplitude in force after this cycle's clock edge,
// so the top level can build the sample from the same tick's new amplitude.
module tone_envelope
    import tone_synth_pkg::*;
#(
    parameter logic [15:0] AMP_MAX      = 16'd12000,
    parameter logic [15:0] ATTACK_STEP  = 16'd400,
    parameter logic [15:0] RELEASE_STEP = 16'd200
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        sample_tick,
    input  logic        sound_en,
    output logic [15:0] amp,
    output logic        busy,
    output logic        restart
);

    env_state_t  state;
    env_state_t  state_next;
    logic [15:0] amp_q;
    logic [16:0] attack_sum;
    logic [15:0] attack_amp;
    logic [15:0] release_amp;

    // Saturating attack and release candidates computed from the current amplitude
    always_comb begin
        attack_sum  = {1'b0, amp_q} + {1'b0, ATTACK_STEP};
        attack_amp  = (attack_sum >= {1'b0, AMP_MAX}) ? AMP_MAX : attack_sum[15:0];
        release_amp = (amp_q > RELEASE_STEP) ? (amp_q - RELEASE_STEP) : 16'd0;
    end

    // Envelope transition rules, evaluated only on sample ticks
    always_comb begin
        state_next = state;
        amp        = amp_q;
        restart    = 1'b0;
        if (sample_tick) begin
            case (state)
                IDLE: begin
                    if (sound_en) begin
                        restart    = 1'b1;
                        amp        = attack_amp;
                        state_next = (attack_amp == AMP_MAX) ? SUSTAIN : ATTACK;
                    end
                end
                ATTACK, RELEASE: begin
                    if (sound_en) begin
                        amp        = attack_amp;
                        state_next = (attack_amp == AMP_MAX) ? SUSTAIN : ATTACK;
                    end else begin
                        amp        = release_amp;
                        state_next = (release_amp == 16'd0) ? IDLE : RELEASE;
                    end
                end
                SUSTAIN: begin
                    if (sound_en) begin
                        amp = AMP_MAX;
                    end else begin
                        amp        = release_amp;
                        state_next = (release_amp == 16'd0) ? IDLE : RELEASE;
                    end
                end
                default: begin
                    amp        = 16'd0;
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, amplitude and busy flag registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            amp_q <= 16'd0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            amp_q <= amp;
            busy  <= (state_next != IDLE);
        end
    end

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone synthesizer: phase accumulator, sign select and output
// registers around the envelope generator.
module tone_synth
    import tone_synth_pkg::*;
#(
    parameter logic [15:0] AMP_MAX      = 16'd12000,
    parameter logic [15:0] ATTACK_STEP  = 16'd400,
    parameter logic [15:0] RELEASE_STEP = 16'd200,
    parameter logic [8:0]  INC_SCALE    = DEFAULT_INC_SCALE
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       sample_tick,
    input  logic [FREQ_W-1:0]          freq,
    input  logic                       sound_en,
    output logic signed [SAMPLE_W-1:0] sample,
    output logic                       sample_valid,
    output logic                       busy
);

    logic [PHASE_W-1:0]  phase;
    logic [PHASE_W-1:0]  phase_next;
    logic [PHASE_W-1:0]  inc;
    logic [18:0]         product;
    logic [15:0]         amp;
    logic                restart;
    logic [SAMPLE_W-1:0] sample_next;

    tone_envelope #(
        .AMP_MAX      (AMP_MAX),
        .ATTACK_STEP  (ATTACK_STEP),
        .RELEASE_STEP (RELEASE_STEP)
    ) u_envelope (
        .clk         (clk),
        .resetN      (resetN),
        .sample_tick (sample_tick),
        .sound_en    (sound_en),
        .amp         (amp),
        .busy        (busy),
        .restart     (restart)
    );

    assign product = 19'(freq) * 19'(INC_SCALE);
    assign inc     = {5'd0, product};

    // Phase restarts on a new note, advances only while a tone is active, and the sign follows its MSB
    always_comb begin
        phase_next = phase;
        if (restart) begin
            phase_next = '0;
        end else if (sample_tick && busy) begin
            phase_next = phase + inc;
        end
        sample_next = phase_next[PHASE_W-1] ? (16'd0 - amp) : amp;
    end

    // Phase accumulator and output sample registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            phase        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            phase        <= phase_next;
            sample_valid <= sample_tick;
            if (sample_tick) begin
                sample <= sample_next;
            end
        end
    end

endmodule

// File: tb/tb_tone_synth.sv
// Self-checking bench for tone_synth: vector table, directed envelope
// sequences and a randomized run against a behavioural model.
module tb_tone_synth;

    localparam int AMP_MAX  = 12000;
    localparam int ATK      = 400;
    localparam int REL      = 200;
    localparam int SCALE    = 350;
    localparam int PH_MOD   = 1 << 24;
    localparam int PH_HALF  = 1 << 23;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               sample_tick = 1'b0;
    logic [9:0]         freq = 10'd0;
    logic               sound_en = 1'b0;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    int  m_phase  = 0;
    int  m_amp    = 0;
    bit  m_active = 0;

    typedef struct {
        bit en;
        int f;
        int exp_sample;
        bit exp_busy;
    } vec_t;

    vec_t vecs[11];

    tone_synth dut (
        .clk          (clk),
        .resetN       (resetN),
        .sample_tick  (sample_tick),
        .freq         (freq),
        .sound_en     (sound_en),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    always #10 clk = ~clk;

    // record one comparison
    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic applyReset();
        sample_tick = 1'b0;
        sound_en    = 1'b0;
        resetN      = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
    endtask

    // one isolated tick; outputs are stable at the following negedge
    task automatic applyStimulus(input bit en, input int f);
        @(negedge clk);
        sound_en    = en;
        freq        = f[9:0];
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    // reference behaviour: a note starts from phase 0, otherwise the phase runs while a tone is audible
    task automatic modelStep(input bit en, input int f);
        if (en) begin
            if (!m_active) begin
                m_phase  = 0;
                m_amp    = (ATK < AMP_MAX) ? ATK : AMP_MAX;
                m_active = 1;
            end else begin
                m_phase = (m_phase + f * SCALE) % PH_MOD;
                m_amp   = (m_amp + ATK > AMP_MAX) ? AMP_MAX : m_amp + ATK;
            end
        end else if (m_active) begin
            m_phase = (m_phase + f * SCALE) % PH_MOD;
            m_amp   = (m_amp - REL < 0) ? 0 : m_amp - REL;
            if (m_amp == 0) m_active = 0;
        end
    endtask

    function automatic int modelSample();
        return (m_phase >= PH_HALF) ? -m_amp : m_amp;
    endfunction

    initial begin
        vecs[0]  = '{0, 480,    0, 0};
        vecs[1]  = '{1, 480,  400, 1};
        vecs[2]  = '{1, 480,  800, 1};
        vecs[3]  = '{0, 480,  600, 1};
        vecs[4]  = '{1,   0, 1000, 1};
        vecs[5]  = '{0,   0,  800, 1};
        vecs[6]  = '{0,   0,  600, 1};
        vecs[7]  = '{0,   0,  400, 1};
        vecs[8]  = '{0,   0,  200, 1};
        vecs[9]  = '{0,   0,    0, 0};
        vecs[10] = '{0, 480,    0, 0};

        applyReset();
        checkOutput("reset_sample", int'(sample), 0);
        checkOutput("reset_valid", int'(sample_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);

        // silence while disabled
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 480);
            checkOutput("idle_sample", int'(sample), 0);
            checkOutput("idle_busy", int'(busy), 0);
            checkOutput("idle_valid", int'(sample_valid), 1);
            @(negedge clk);
            checkOutput("idle_valid_pulse", int'(sample_valid), 0);
        end

        // vector table
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].en, vecs[i].f);
            checkOutput($sformatf("vec%0d_sample", i), int'(sample), vecs[i].exp_sample);
            checkOutput($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d_valid", i), int'(sample_valid), 1);
        end

        // attack to sustain at 480 Hz, first sign change at tick 51
        applyReset();
        for (int k = 1; k <= 51; k++) begin
            applyStimulus(1, 480);
            if (k == 29) checkOutput("attack_t29", int'(sample), 11600);
            if (k == 30) checkOutput("attack_t30", int'(sample), 12000);
            if (k == 50) checkOutput("sustain_t50", int'(sample), 12000);
            if (k == 51) checkOutput("sustain_t51", int'(sample), -12000);
        end
        checkOutput("sustain_busy", int'(busy), 1);

        // switch to 960 Hz: half period becomes 25 ticks
        for (int k = 1; k <= 50; k++) begin
            applyStimulus(1, 960);
            checkOutput("f960_mag", iabs(int'(sample)), 12000);
            if (k == 24) checkOutput("f960_t24", int'(sample), -12000);
            if (k == 25) checkOutput("f960_t25", int'(sample), 12000);
            if (k == 49) checkOutput("f960_t49", int'(sample), 12000);
            if (k == 50) checkOutput("f960_t50", int'(sample), -12000);
        end

        // full release: 60 ticks to zero
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(0, 960);
            checkOutput("release_mag", iabs(int'(sample)), 12000 - 200 * k);
            checkOutput("release_busy", int'(busy), (k < 60) ? 1 : 0);
        end

        // re-attack during release at amp 6000, phase continues
        for (int k = 1; k <= 61; k++) begin
            applyStimulus((k <= 30 || k == 61) ? 1'b1 : 1'b0, 480);
            if (k == 60) checkOutput("rel_t60", int'(sample), -6000);
            if (k == 61) checkOutput("reattack_t61", int'(sample), -6400);
        end

        // reset mid-attack with a tick on the same cycle
        applyReset();
        for (int k = 0; k < 5; k++) applyStimulus(1, 480);
        @(negedge clk);
        sound_en    = 1'b1;
        sample_tick = 1'b1;
        resetN      = 1'b0;
        @(negedge clk);
        checkOutput("rst_sample", int'(sample), 0);
        checkOutput("rst_valid", int'(sample_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        sample_tick = 1'b0;
        resetN      = 1'b1;
        @(negedge clk);
        applyStimulus(1, 480);
        checkOutput("post_rst_sample", int'(sample), 400);
        checkOutput("post_rst_busy", int'(busy), 1);

        // randomized run against the model, including back-to-back ticks
        applyReset();
        m_phase  = 0;
        m_amp    = 0;
        m_active = 0;
        begin
            bit prev_tick = 0;
            bit en_r      = 0;
            int f_r       = 480;
            int exp_s     = 0;
            for (int c = 0; c < 4000; c++) begin
                @(negedge clk);
                checkOutput("rnd_valid", int'(sample_valid), int'(prev_tick));
                checkOutput("rnd_sample", int'(sample), exp_s);
                checkOutput("rnd_busy", int'(busy), int'(m_active));
                if ($urandom_range(0, 99) == 0) en_r = ~en_r;
                if ($urandom_range(0, 199) == 0) f_r = $urandom_range(0, 1023);
                prev_tick   = ($urandom_range(0, 1) == 1);
                sound_en    = en_r;
                freq        = f_r[9:0];
                sample_tick = prev_tick;
                if (prev_tick) begin
                    modelStep(en_r, f_r);
                    exp_s = modelSample();
                end
            end
            @(negedge clk);
            sample_tick = 1'b0;
            checkOutput("rnd_final_sample", int'(sample), exp_s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
